// File: rtl/sram_stream_reader.sv
// Streams a burst of consecutive SRAM words to a valid/ready sink, one word in flight at a time.
// Each word is fetched, held until the sink accepts it, then the next address is issued.
module sram_stream_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] sramAddr,
  output logic                  sramWr,
  output logic [DATA_WIDTH-1:0] sramDataIn,
  input  logic [DATA_WIDTH-1:0] sramDataOut,
  output logic                  outValid,
  output logic [DATA_WIDTH-1:0] outData,
  input  logic                  outReady,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [2:0]            LAT      = 3'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
  logic [2:0]              wait_cnt_q, wait_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start && (count != '0)) state_d = S_WAIT;
      S_WAIT: if (wait_cnt_q == LAT) state_d = S_OUT;
      S_OUT:  if (outReady) state_d = (remaining_q > REM_ONE) ? S_WAIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // An empty burst completes immediately without touching the SRAM.
          if (count != '0) begin
            addr_d      = baseAddr;
            remaining_d = count;
            busy_d      = 1'b1;
            wait_cnt_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 3'd1;
        if (wait_cnt_q == LAT) begin
          out_data_d  = sramDataOut;
          out_valid_d = 1'b1;
        end
      end
      S_OUT: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q > REM_ONE) begin
            addr_d     = addr_q + ADDR_ONE;
            wait_cnt_d = '0;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign sramAddr   = addr_q;
  assign sramWr     = 1'b0;
  assign sramDataIn = '0;
  assign outValid   = out_valid_q;
  assign outData    = out_data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// Bench for sram_stream_reader: behavioural SRAM, scoreboard of (address, word) pairs checked
// on every accepted transfer, plus per-scenario checks of timing, done pulses and reset.
module tb_sram_stream_reader;

  localparam int RL = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] count = '0;
  logic [7:0] sram_addr;
  logic       sram_wr;
  logic [7:0] sram_data_in;
  logic [7:0] sram_data_out;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;

  sram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(base_addr), .count(count),
    .sramAddr(sram_addr), .sramWr(sram_wr), .sramDataIn(sram_data_in),
    .sramDataOut(sram_data_out), .outValid(out_valid), .outData(out_data),
    .outReady(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM with RL-stage registered read
  logic [7:0] mem [0:255];
  logic [7:0] dpipe [0:RL-1];
  always @(posedge clk) begin
    dpipe[0] <= mem[sram_addr];
    for (int i = 1; i < RL; i++) dpipe[i] <= dpipe[i-1];
  end
  assign sram_data_out = dpipe[RL-1];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int vec = 0;
  int err = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_data = '0;
  logic done_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        vec++;
        stall_cnt++;
        if (out_valid !== 1'b1 || out_data !== stall_data) begin
          err++;
          $display("FAIL stall_hold: valid=%0b data=%0d, required valid=1 data=%0d", out_valid, out_data, stall_data);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vec++;
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          err++;
          $display("FAIL unexpected_word: addr=%0d data=%0d, required no transfer", sram_addr, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e.data || sram_addr !== mon_e.addr) begin
            err++;
            $display("FAIL word: addr=%0d data=%0d, required addr=%0d data=%0d", sram_addr, out_data, mon_e.addr, mon_e.data);
          end else begin
            $display("xfer addr=%0d data=%0d", sram_addr, out_data);
          end
        end
      end
      stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1);
      stall_data = out_data;
      if (done === 1'b1) begin
        vec++;
        done_cnt++;
        if (done_prev) begin
          err++;
          $display("FAIL done_width: done high on consecutive cycles, required single-cycle pulse");
        end
      end
      done_prev = (done === 1'b1);
    end else begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end
  end

  task automatic push_burst(input logic [7:0] base, input int n);
    logic [7:0] a;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      a = base + 8'(k);
      e.addr = a;
      e.data = mem[a];
      exp_q.push_back(e);
    end
  endtask

  // Called and returns at #1 after a posedge; the posedge inside is the start-sampling edge.
  task automatic kick(input logic [7:0] base, input logic [8:0] cnt);
    base_addr = base;
    count = cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    vec++;
    if (done !== 1'b1) begin
      err++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic settle_and_check(input int d0, input int dones);
    @(posedge clk); #1;
    vec++;
    if (done_cnt - d0 !== dones) begin
      err++;
      $display("FAIL done_count: got %0d, required %0d", done_cnt - d0, dones);
    end
    vec++;
    if (exp_q.size() !== 0) begin
      err++;
      $display("FAIL words_missing: %0d expected words not delivered, required 0", exp_q.size());
    end
    vec++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL idle_after_burst: busy=%0b done=%0b valid=%0b, required 0 0 0", busy, done, out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    base_addr = 8'd33;
    count = 9'd5;
    @(posedge clk); @(posedge clk); #1;
    vec++;
    if (sram_addr !== 8'd0 || out_valid !== 1'b0 || out_data !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      err++;
      $display("FAIL reset_state: addr=%0d valid=%0b data=%0d busy=%0b done=%0b, required all 0", sram_addr, out_valid, out_data, busy, done);
    end
    vec++;
    if (sram_wr !== 1'b0 || sram_data_in !== 8'd0) begin
      err++;
      $display("FAIL write_port: wr=%0b din=%0d, required 0 0", sram_wr, sram_data_in);
    end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int n;
    int d0;
    d0 = done_cnt;
    out_ready = 1'b1;
    push_burst(8'd0, 10);
    kick(8'd0, 9'd10);
    vec++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL start_edge: busy=%0b valid=%0b, required 1 0", busy, out_valid);
    end
    @(posedge clk); #1;
    vec++;
    if (out_valid !== 1'b0) begin
      err++;
      $display("FAIL latency_early: valid=%0b one edge after start, required 0", out_valid);
    end
    @(posedge clk); #1;
    vec++;
    if (out_valid !== 1'b1 || out_data !== 8'd50) begin
      err++;
      $display("FAIL first_word: valid=%0b data=%0d two edges after start, required 1 50", out_valid, out_data);
    end
    wait_done(200, n);
    vec++;
    if (n !== 28) begin
      err++;
      $display("FAIL throughput: done %0d edges after first word, required 28", n);
    end
    settle_and_check(d0, 1);
  endtask

  task automatic test_stall();
    int n;
    int d0;
    int s0;
    d0 = done_cnt;
    s0 = stall_cnt;
    out_ready = 1'b0;
    push_burst(8'd0, 10);
    kick(8'd0, 9'd10);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      out_ready = (n % 4 == 3);
      @(posedge clk); #1;
      n++;
    end
    vec++;
    if (done !== 1'b1) begin
      err++;
      $display("FAIL stall_timeout: done=%0b after %0d cycles, required 1", done, n);
    end
    vec++;
    if (stall_cnt == s0) begin
      err++;
      $display("FAIL stall_coverage: %0d stalled cycles seen, required >0", stall_cnt - s0);
    end
    out_ready = 1'b1;
    settle_and_check(d0, 1);
  endtask

  task automatic test_wrap();
    int n;
    int d0;
    d0 = done_cnt;
    mem[254] = 8'd7;
    mem[255] = 8'd8;
    mem[0]   = 8'd9;
    mem[1]   = 8'd10;
    out_ready = 1'b1;
    push_burst(8'd254, 4);
    kick(8'd254, 9'd4);
    wait_done(100, n);
    settle_and_check(d0, 1);
    mem[0] = 8'd50;
    mem[1] = 8'd51;
  endtask

  task automatic test_zero_count();
    int d0;
    d0 = done_cnt;
    kick(8'd20, 9'd0);
    vec++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL zero_count: done=%0b busy=%0b valid=%0b, required 1 0 0", done, busy, out_valid);
    end
    settle_and_check(d0, 1);
  endtask

  task automatic test_reset_mid_burst();
    int n;
    int d0;
    int x0;
    x0 = xfer_cnt;
    out_ready = 1'b1;
    push_burst(8'd0, 10);
    kick(8'd0, 9'd10);
    n = 0;
    while (xfer_cnt < x0 + 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    vec++;
    if (xfer_cnt < x0 + 3) begin
      err++;
      $display("FAIL three_words_timeout: %0d words after %0d cycles, required 3", xfer_cnt - x0, n);
    end
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    vec++;
    if (sram_addr !== 8'd0 || out_valid !== 1'b0 || out_data !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      err++;
      $display("FAIL abort_state: addr=%0d valid=%0b data=%0d busy=%0b done=%0b, required all 0", sram_addr, out_valid, out_data, busy, done);
    end
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (done_cnt !== d0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      err++;
      $display("FAIL abort_quiet: dones=%0d valid=%0b busy=%0b, required 0 0 0", done_cnt - d0, out_valid, busy);
    end
    push_burst(8'd5, 2);
    kick(8'd5, 9'd2);
    wait_done(100, n);
    settle_and_check(d0, 1);
  endtask

  task automatic test_ignore_start();
    int n;
    int d0;
    d0 = done_cnt;
    mem[100] = 8'hAA;
    out_ready = 1'b1;
    push_burst(8'd0, 10);
    kick(8'd0, 9'd10);
    repeat (4) @(posedge clk);
    #1;
    kick(8'd100, 9'd5);
    vec++;
    if (busy !== 1'b1) begin
      err++;
      $display("FAIL busy_mid_burst: busy=%0b, required 1", busy);
    end
    wait_done(200, n);
    settle_and_check(d0, 1);
    vec++;
    if (sram_addr !== 8'd9) begin
      err++;
      $display("FAIL idle_addr_hold: addr=%0d, required 9", sram_addr);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int d0;
    d0 = done_cnt;
    out_ready = 1'b1;
    push_burst(8'd3, 1);
    push_burst(8'd3, 1);
    base_addr = 8'd3;
    count = 9'd1;
    start = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      err++;
      $display("FAIL b2b_done_edge: done=%0b busy=%0b, required 1 0", done, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      err++;
      $display("FAIL b2b_restart: done=%0b busy=%0b, required 0 1", done, busy);
    end
    wait_done(50, n);
    settle_and_check(d0, 2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 10; i++) mem[i] = 8'(50 + i);
    for (int i = 0; i < RL; i++) dpipe[i] = '0;
    test_reset();
    test_stream();
    test_stall();
    test_wrap();
    test_zero_count();
    test_reset_mid_burst();
    test_ignore_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_stream_reader.md
SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 8, SRAM address width.
REQ-003 Parameter READ_LATENCY, default 1, clock edges from SRAM address valid to SRAM dataOut valid; legal range 1-4.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 start  input  1  one-cycle burst request; sampled only in IDLE.
REQ-007 baseAddr  input  ADDR_WIDTH  first SRAM address of the burst; sampled with start.
REQ-008 count  input  ADDR_WIDTH+1  number of words to read, 0..2^ADDR_WIDTH; sampled with start.
REQ-009 sramAddr  output  ADDR_WIDTH  SRAM address.
REQ-010 sramWr  output  1  SRAM write enable; constant 0.
REQ-011 sramDataIn  output  DATA_WIDTH  SRAM write data; constant 0.
REQ-012 sramDataOut  input  DATA_WIDTH  SRAM read data.
REQ-013 outValid  output  1  outData holds a valid word.
REQ-014 outData  output  DATA_WIDTH  streamed word.
REQ-015 outReady  input  1  downstream accepts the word when outValid and outReady are both high at a posedge.
REQ-016 busy  output  1  high from the cycle after start is accepted until the final word transfers.
REQ-017 done  output  1  one-cycle pulse at burst completion.

Function
REQ-018 FSM states: IDLE, WAIT, OUT; only one word is in flight at a time.
REQ-019 IDLE with start=1 and count!=0: sramAddr<=baseAddr, remaining<=count, busy<=1, waitCnt<=0, go to WAIT.
REQ-020 IDLE with start=1 and count=0: done pulses for one cycle on the next edge; busy stays 0; outValid never asserts.
REQ-021 WAIT: waitCnt increments each edge; on the edge where waitCnt=READ_LATENCY, outData<=sramDataOut, outValid<=1, go to OUT.
REQ-022 Latency: outValid rises READ_LATENCY+1 edges after the start-accepting edge, and READ_LATENCY+1 edges after each sramAddr update.
REQ-023 OUT: outValid and outData hold stable while outReady=0, with no timeout.
REQ-024 OUT transfer with remaining>1: outValid<=0, remaining<=remaining-1, sramAddr<=sramAddr+1, waitCnt<=0, go to WAIT.
REQ-025 OUT transfer with remaining=1: outValid<=0, busy<=0, done<=1 for exactly one cycle, go to IDLE.
REQ-026 sramAddr increments modulo 2^ADDR_WIDTH; a burst crossing the top address wraps to 0.
REQ-027 count=2^ADDR_WIDTH reads every address exactly once.
REQ-028 start while busy=1 is ignored, with no effect on the current burst.
REQ-029 start on the same edge that done is generated is ignored; a new start is accepted from the following cycle.
REQ-030 sramAddr holds its last value while in IDLE.
REQ-031 Sustained throughput with outReady=1: one word per READ_LATENCY+2 cycles.

Reset
REQ-032 rst=1 at a posedge: state<=IDLE, sramAddr=0, outValid=0, outData=0, busy=0, done=0, remaining=0, waitCnt=0.
REQ-033 rst mid-burst aborts the burst; no done pulse is issued, and an in-flight word is discarded.
REQ-034 rst has priority over start in the same cycle.

Verification
REQ-035 SRAM preloaded addr 0..9 = 50..59; baseAddr=0, count=10, outReady=1 -> outData sequence 50..59; exactly one done; first outValid 2 edges after start (READ_LATENCY=1).
REQ-036 Same preload; outReady toggles 0 for 3 cycles per word -> same 10 values in order; outData is stable during every stall.
REQ-037 Preload 254=7, 255=8, 0=9, 1=10; baseAddr=254, count=4 -> sramAddr sequence 254, 255, 0, 1; outData sequence 7, 8, 9, 10.
REQ-038 count=0 start -> done high for one cycle on the next edge; busy and outValid remain 0.
REQ-039 rst asserted after the 3rd word of a 10-word burst -> all outputs 0 next edge, no done; a following burst with baseAddr=5, count=2 yields 55, 56.
REQ-040 start pulsed again mid-burst with baseAddr=100 -> ignored; the original burst output is unchanged.
